// File: rtl/control_sequencer.sv
// Microcoded T-state sequencer for the 8-bit bus computer: steps fetch/execute
// T-states and decodes (state, opcode, zero_flag) into the register-bus strobes.
module control_sequencer #(
  parameter bit HALT_ON_UNDEF = 1'b0
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       run,
  input  logic [3:0] opcode,
  input  logic       zero_flag,
  output logic       pc_oe,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       mar_load,
  output logic       ram_oe,
  output logic       ram_we,
  output logic       ir_load,
  output logic       ir_oe,
  output logic       a_load,
  output logic       a_oe,
  output logic       b_load,
  output logic       b_oe,
  output logic       alu_oe,
  output logic       alu_sub,
  output logic       out_load,
  output logic [2:0] tstate,
  output logic       halted
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T1   = 4'd1,
    S_T2   = 4'd2,
    S_T3   = 4'd3,
    S_T4   = 4'd4,
    S_T5   = 4'd5,
    S_T6   = 4'd6,
    S_T7   = 4'd7,
    S_HALT = 4'd8
  } state_e;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_LDA = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_LDB = 4'b0100;
  localparam logic [3:0] OP_STA = 4'b0101;
  localparam logic [3:0] OP_JMP = 4'b0110;
  localparam logic [3:0] OP_JZ  = 4'b0111;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  state_e state_q, state_d;
  logic   is_undef;
  logic   instr_end;
  logic   to_halt;

  // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  assign is_undef = (opcode >= 4'b1000) && (opcode <= 4'b1101);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_d   = state_q;
    instr_end = 1'b0;
    to_halt   = 1'b0;
    unique case (state_q)
      S_IDLE: if (run) state_d = S_T1;
      S_T1:   state_d = S_T2;
      S_T2:   state_d = S_T3;
      S_T3: begin
        if (is_undef && HALT_ON_UNDEF)          to_halt   = 1'b1;
        else if (opcode == OP_NOP || is_undef)  instr_end = 1'b1;
        else                                    state_d   = S_T4;
      end
      S_T4: begin
        if (opcode == OP_HLT) to_halt = 1'b1;
        else if (opcode == OP_JMP || opcode == OP_JZ || opcode == OP_OUT) instr_end = 1'b1;
        else state_d = S_T5;
      end
      S_T5: begin
        if (opcode == OP_ADD || opcode == OP_SUB) state_d   = S_T6;
        else                                      instr_end = 1'b1;
      end
      S_T6:   state_d = S_T7;
      S_T7:   instr_end = 1'b1;
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
    // A pause request only takes effect between instructions.
    if (to_halt)        state_d = S_HALT;
    else if (instr_end) state_d = run ? S_T1 : S_IDLE;
  end

  always_comb begin
    pc_oe    = 1'b0;
    pc_inc   = 1'b0;
    pc_load  = 1'b0;
    mar_load = 1'b0;
    ram_oe   = 1'b0;
    ram_we   = 1'b0;
    ir_load  = 1'b0;
    ir_oe    = 1'b0;
    a_load   = 1'b0;
    a_oe     = 1'b0;
    b_load   = 1'b0;
    b_oe     = 1'b0;
    alu_oe   = 1'b0;
    alu_sub  = 1'b0;
    out_load = 1'b0;
    unique case (state_q)
      S_T1: begin
        pc_oe    = 1'b1;
        mar_load = 1'b1;
      end
      S_T2: begin
        ram_oe  = 1'b1;
        ir_load = 1'b1;
        pc_inc  = 1'b1;
      end
      S_T4: begin
        unique case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_LDB, OP_STA: begin
            ir_oe    = 1'b1;
            mar_load = 1'b1;
          end
          OP_JMP: begin
            ir_oe   = 1'b1;
            pc_load = 1'b1;
          end
          OP_JZ: begin
            ir_oe   = zero_flag;
            pc_load = zero_flag;
          end
          OP_OUT: begin
            a_oe     = 1'b1;
            out_load = 1'b1;
          end
          default: ;
        endcase
      end
      S_T5: begin
        unique case (opcode)
          OP_LDA: begin
            ram_oe = 1'b1;
            a_load = 1'b1;
          end
          OP_ADD, OP_SUB, OP_LDB: begin
            ram_oe = 1'b1;
            b_load = 1'b1;
          end
          OP_STA: begin
            a_oe   = 1'b1;
            ram_we = 1'b1;
          end
          default: ;
        endcase
      end
      S_T6: begin
        b_oe    = 1'b1;
        alu_sub = (opcode == OP_SUB);
      end
      S_T7: begin
        alu_oe  = 1'b1;
        a_load  = 1'b1;
        alu_sub = (opcode == OP_SUB);
      end
      default: ;
    endcase
  end

  assign tstate = (state_q == S_IDLE || state_q == S_HALT) ? 3'd0 : state_q[2:0];
  assign halted = (state_q == S_HALT);

endmodule
